// File: rtl/data_mem_if.sv
// Request/response bus between the datapath memory stage and the data memory.
interface data_mem_if;
  logic        req;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, be, addr, wdata,
    input  addr_ok, data_ok, rdata, err, busy
  );

  modport slave (
    input  req, wr, be, addr, wdata,
    output addr_ok, data_ok, rdata, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed-latency accept/wait/respond handshake.
module data_mem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WAIT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_accept;
  logic                w_enter_resp;

  logic                r_wr;
  logic [3:0]          r_be;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_oor;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_in_oor;
  logic                w_op_wr;
  logic [3:0]          w_op_be;
  logic [ADDR_W-1:0]   w_op_idx;
  logic                w_op_oor;
  logic [DATA_W-1:0]   w_op_wdata;

  logic                r_addr_ok;
  logic                r_data_ok;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  assign w_accept = bus.req & r_addr_ok;
  assign w_in_oor = (bus.addr >> (ADDR_W + 2)) != 32'd0;

  // With WAIT=0 the memory operation happens on the accept edge itself, so take the live bus.
  assign w_op_wr    = (r_state == ST_IDLE) ? bus.wr                   : r_wr;
  assign w_op_be    = (r_state == ST_IDLE) ? bus.be                   : r_be;
  assign w_op_idx   = (r_state == ST_IDLE) ? bus.addr[ADDR_W+1:2]     : r_idx;
  assign w_op_oor   = (r_state == ST_IDLE) ? w_in_oor                 : r_oor;
  assign w_op_wdata = (r_state == ST_IDLE) ? bus.wdata                : r_wdata;

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT == 0) begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = CNT_W'(WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request fields at the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_be    <= '0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= bus.wr;
      r_be    <= bus.be;
      r_idx   <= bus.addr[ADDR_W+1:2];
      r_oor   <= w_in_oor;
      r_wdata <= bus.wdata;
    end
  end

  // Registered handshake outputs and load data, derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_ok <= 1'b1;
      r_busy    <= 1'b0;
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_addr_ok <= (w_next == ST_IDLE);
      r_busy    <= (w_next != ST_IDLE);
      r_data_ok <= w_enter_resp;
      r_err     <= w_enter_resp & w_op_oor;
      if (w_enter_resp) begin
        if (w_op_oor) begin
          r_rdata <= '0;
        end else if (!w_op_wr) begin
          r_rdata <= r_mem[w_op_idx];
        end
      end
    end
  end

  // Byte-lane store; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && w_op_wr && !w_op_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_op_be[i]) begin
          r_mem[w_op_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.addr_ok = r_addr_ok;
  assign bus.data_ok = r_data_ok;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: WAIT=2 instance for the main scenarios, WAIT=0 instance for zero-wait latency.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  data_mem_if bus ();
  data_mem_if bus0 ();

  data_mem_responder #(.ADDR_W(8), .WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  data_mem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One transaction on the WAIT=2 instance; returns at the negedge of the data_ok cycle.
  task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] rd,
                     output logic er, output logic to);
    int n;
    int acc;
    to = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.be = b; bus.addr = a; bus.wdata = d;
    n = 0;
    while (!bus.addr_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) to = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (!bus.data_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) to = 1'b1;
    lat = cyc - acc;
    rd  = bus.rdata;
    er  = bus.err;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.data_ok !== 1'b0) begin n_errors++; $display("FAIL reset_data_ok: got %b want 0", bus.data_ok); end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_first_accept();
    int n;
    int acc;
    @(negedge clk);
    rst = 1'b1;
    bus.req = 1'b1; bus.wr = 1'b1; bus.be = 4'hF; bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF;
    acc = cyc;
    n_checks++; if (bus.addr_ok !== 1'b1) begin n_errors++; $display("FAIL first_addr_ok: got %b want 1", bus.addr_ok); end
    @(negedge clk);
    bus.req = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL first_accept_busy: got %b want 1", bus.busy); end
    n = 0;
    while (!bus.data_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if ((cyc - acc) !== 3) begin n_errors++; $display("FAIL first_latency: got %0d want 3", cyc - acc); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL first_store_rdata: got %h want 0", bus.rdata); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er; logic to;
    txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL store_timeout: got %b want 0", to); end
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL store_latency: got %0d want 3", lat); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL store_err: got %b want 0", er); end
    txn(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, to);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL load_latency: got %0d want 3", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL load_err: got %b want 0", er); end
    @(negedge clk);
    n_checks++; if (bus.rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rdata_hold: got %h want deadbeef", bus.rdata); end
    n_checks++; if (bus.data_ok !== 1'b0) begin n_errors++; $display("FAIL data_ok_pulse: got %b want 0", bus.data_ok); end
  endtask

  task automatic test_byte_merge();
    int lat; logic [31:0] rd; logic er; logic to;
    txn(1'b1, 4'b0010, 32'h10, 32'h0000AA00, lat, rd, er, to);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL store_keeps_rdata: got %h want deadbeef", rd); end
    txn(1'b0, 4'h0, 32'h12, 32'h0, lat, rd, er, to);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_errors++; $display("FAIL merge_rdata: got %h want deadaaef", rd); end
    txn(1'b1, 4'b0000, 32'h10, 32'h55555555, lat, rd, er, to);
    txn(1'b0, 4'hF, 32'h13, 32'h0, lat, rd, er, to);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_errors++; $display("FAIL noop_store_rdata: got %h want deadaaef", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er; logic to;
    txn(1'b1, 4'hF, 32'h0, 32'h12345678, lat, rd, er, to);
    txn(1'b0, 4'h0, 32'h400, 32'h0, lat, rd, er, to);
    n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL oor_err: got %b want 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL oor_rdata: got %h want 0", rd); end
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL err_after_pulse: got %b want 0", bus.err); end
    txn(1'b0, 4'h0, 32'h000, 32'h0, lat, rd, er, to);
    n_checks++; if (rd !== 32'h12345678) begin n_errors++; $display("FAIL after_oor_load: got %h want 12345678", rd); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL after_oor_err: got %b want 0", er); end
    txn(1'b1, 4'hF, 32'h410, 32'hFFFFFFFF, lat, rd, er, to);
    n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL oor_store_err: got %b want 1", er); end
    txn(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, to);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_errors++; $display("FAIL oor_store_alias: got %h want deadaaef", rd); end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n_acc;
    int n_ok;
    int viol;
    logic drop;
    n_acc = 0; n_ok = 0; viol = 0; drop = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.be = 4'h0; bus.addr = 32'h10;
    for (int k = 0; k < 30; k++) begin
      if (drop) bus.req = 1'b0;
      if (bus.addr_ok !== !bus.busy) viol++;
      if (bus.data_ok) n_ok++;
      if (bus.req && bus.addr_ok && n_acc < 3) begin
        acc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 3) drop = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++; if (n_acc !== 3) begin n_errors++; $display("FAIL b2b_accepts: got %0d want 3", n_acc); end
    n_checks++; if ((acc[1] - acc[0]) !== 4) begin n_errors++; $display("FAIL b2b_gap1: got %0d want 4", acc[1] - acc[0]); end
    n_checks++; if ((acc[2] - acc[1]) !== 4) begin n_errors++; $display("FAIL b2b_gap2: got %0d want 4", acc[2] - acc[1]); end
    n_checks++; if (n_ok !== 3) begin n_errors++; $display("FAIL b2b_data_ok: got %0d want 3", n_ok); end
    n_checks++; if (viol !== 0) begin n_errors++; $display("FAIL b2b_addr_ok_busy: got %0d violations want 0", viol); end
    n_checks++; if (bus.rdata !== 32'hDEADAAEF) begin n_errors++; $display("FAIL b2b_rdata: got %h want deadaaef", bus.rdata); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er; logic to;
    int n_ok;
    txn(1'b1, 4'hF, 32'h20, 32'h11111111, lat, rd, er, to);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.be = 4'hF; bus.addr = 32'h20; bus.wdata = 32'h22222222;
    @(negedge clk);
    bus.req = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL abort_in_wait: got busy %b want 1", bus.busy); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.data_ok !== 1'b0) begin n_errors++; $display("FAIL abort_data_ok: got %b want 0", bus.data_ok); end
    @(negedge clk);
    rst = 1'b1;
    n_ok = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.data_ok) n_ok++;
    end
    n_checks++; if (n_ok !== 0) begin n_errors++; $display("FAIL abort_stray_data_ok: got %0d want 0", n_ok); end
    txn(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er, to);
    n_checks++; if (rd !== 32'h11111111) begin n_errors++; $display("FAIL abort_mem: got %h want 11111111", rd); end
  endtask

  task automatic test_wait0();
    int acc;
    int busy_cnt;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus0.req = 1'b1; bus0.wr = (t == 0); bus0.be = 4'hF;
      bus0.addr = 32'h40; bus0.wdata = 32'hCAFEF00D;
      n_checks++; if (bus0.addr_ok !== 1'b1) begin n_errors++; $display("FAIL w0_addr_ok: got %b want 1", bus0.addr_ok); end
      acc = cyc;
      busy_cnt = 0;
      @(negedge clk);
      bus0.req = 1'b0;
      n_checks++; if (bus0.data_ok !== 1'b1 || (cyc - acc) !== 1) begin n_errors++; $display("FAIL w0_latency: got data_ok %b at +%0d want 1 at +1", bus0.data_ok, cyc - acc); end
      if (bus0.busy) busy_cnt++;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (bus0.busy) busy_cnt++;
      end
      n_checks++; if (busy_cnt !== 1) begin n_errors++; $display("FAIL w0_busy_cycles: got %0d want 1", busy_cnt); end
    end
    n_checks++; if (bus0.rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL w0_rdata: got %h want cafef00d", bus0.rdata); end
  endtask

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.be = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.be = 4'h0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
    test_reset();
    test_first_accept();
    test_store_load();
    test_byte_merge();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    test_wait0();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 2: wait cycles inserted between accept and response; legal range 0..15.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  memory-stage request valid from the datapath.
REQ-006 wr  input  1  1 = store, 0 = load; sampled with req.
REQ-007 be  input  4  byte write enables (waM-style), bit i enables wdata[8i+7:8i]; ignored on loads.
REQ-008 addr  input  32  byte address (aluoutM); addr[1:0] ignored.
REQ-009 wdata  input  32  store data, already lane-aligned (writedataM).
REQ-010 addr_ok  output  1  request accepted this cycle when high together with req.
REQ-011 data_ok  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  load data, valid while data_ok=1 and held afterwards.
REQ-013 err  output  1  out-of-range flag, valid only with data_ok.
REQ-014 busy  output  1  high from the accept edge until the data_ok cycle inclusive.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 In IDLE: addr_ok=1 and busy=0. In WAIT and RESP: addr_ok=0 and busy=1.
REQ-017 When req & addr_ok, the block SHALL latch wr, be, addr and wdata at the edge. It SHALL load the wait counter with WAIT-1 and enter WAIT, or enter RESP directly if WAIT=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle. On the edge where the counter equals 0, the state SHALL become RESP.
REQ-019 In RESP: data_ok=1 for exactly one cycle, then unconditional return to IDLE. A req present during RESP is not accepted that cycle.
REQ-020 Latency: data_ok SHALL be high in cycle A+WAIT+1, where A is the accept cycle. Back-to-back throughput is one transaction per WAIT+2 cycles.
REQ-021 The word index SHALL be addr[ADDR_W+1:2]. A request is out of range when addr[31:ADDR_W+2] is not 0.
REQ-022 In-range store: on the edge entering RESP, write only the byte lanes with be=1; lanes with be=0 are unchanged. be=4'b0000 is a legal no-op store. rdata is unchanged and err=0.
REQ-023 In-range load: on the edge entering RESP, rdata SHALL take the full addressed word regardless of be. err=0.
REQ-024 Out-of-range request: no memory write, rdata=0, err=1 during the data_ok cycle.
REQ-025 err SHALL be 0 whenever data_ok=0.
REQ-026 A load after a store to the same word SHALL return the merged post-store value.
REQ-027 Memory array contents are not reset and are undefined until written.

Reset
REQ-028 When rst=0, asynchronously: state=IDLE, counter=0, data_ok=0, err=0, rdata=0, busy=0, and addr_ok=1 once reset is released.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transaction: no memory update if the write edge has not occurred, and no data_ok pulse after release.
REQ-030 The first accept after release is possible in the first cycle with rst=1.

Verification
REQ-031 WAIT=2, store addr=0x10, be=1111, wdata=0xDEADBEEF, then load 0x10 -> each data_ok is 3 cycles after its accept; load rdata=0xDEADBEEF, err=0.
REQ-032 Word 0x10 = 0xDEADBEEF; store be=0010, wdata=0x0000AA00; load 0x12 -> rdata=0xDEADAAEF.
REQ-033 ADDR_W=8, load addr=0x400 -> data_ok with err=1, rdata=0. A subsequent load of 0x000 returns unchanged contents.
REQ-034 req held high continuously for 3 loads -> addr_ok only in IDLE cycles; accepts exactly 4 cycles apart; exactly 3 data_ok pulses.
REQ-035 Store 0x20 = 0x11111111. Start store 0x20 = 0x22222222 and pull rst low in WAIT. Release, load 0x20 -> 0x11111111; no stray data_ok after reset.
REQ-036 WAIT=0, load accepted in cycle A -> data_ok in A+1, busy high for exactly one cycle.
